// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO sequencer around a 1R1W registered-read RAM, with a 2-entry output skid buffer.
// Define RAM_FIFO_LEVEL_EN to add the level / almost_full status outputs.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic              r_rd_pend;
    logic [1:0]        r_ob_cnt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              r_s_ready;

    logic              w_push;
    logic              w_pop;
    logic              w_re;
    logic [1:0]        w_keep;
    logic [1:0]        w_ob_cnt_next;
    logic [ADDR_W:0]   w_mem_cnt_next;
    logic [ADDR_W-1:0] w_wptr_inc;
    logic [ADDR_W-1:0] w_rptr_inc;
    logic [DATA_W-1:0] w_head_next;
    logic [DATA_W-1:0] w_tail_next;

    assign w_push = s_valid & r_s_ready;
    assign w_pop  = (r_ob_cnt != 2'd0) & m_ready;

    // Skid entries still held after this cycle's pop.
    assign w_keep = r_ob_cnt - {1'b0, w_pop};

    // Only issue a read if the skid can take it once it lands, counting the one in flight.
    assign w_re          = (r_mem_cnt != '0) && ((w_keep + {1'b0, r_rd_pend}) < 2'd2);
    assign w_ob_cnt_next = w_keep + {1'b0, r_rd_pend};

    assign w_wptr_inc = (r_wptr == LP_LAST) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == LP_LAST) ? '0 : r_rptr + 1'b1;

    always_comb begin
        w_mem_cnt_next = r_mem_cnt;
        if (w_push && !w_re) begin
            w_mem_cnt_next = r_mem_cnt + 1'b1;
        end else if (!w_push && w_re) begin
            w_mem_cnt_next = r_mem_cnt - 1'b1;
        end
    end

    always_comb begin
        w_head_next = w_pop ? r_tail : r_head;
        w_tail_next = r_tail;
        if (r_rd_pend) begin
            if (w_keep == 2'd1) begin
                w_tail_next = ram_rdata;
            end else begin
                w_head_next = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_ob_cnt  <= 2'd0;
            r_head    <= '0;
            r_tail    <= '0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_re) begin
                r_rptr <= w_rptr_inc;
            end
            r_mem_cnt <= w_mem_cnt_next;
            r_rd_pend <= w_re;
            r_ob_cnt  <= w_ob_cnt_next;
            r_head    <= w_head_next;
            r_tail    <= w_tail_next;
            r_s_ready <= (w_mem_cnt_next < LP_DEPTH);
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = (r_ob_cnt != 2'd0);
    assign m_data    = r_head;
    assign ram_we    = w_push;
    assign ram_waddr = r_wptr;
    assign ram_wdata = s_data;
    assign ram_re    = w_re;
    assign ram_raddr = r_rptr;

`ifdef RAM_FIFO_LEVEL_EN
    logic [ADDR_W+1:0] r_level;
    logic              r_almost_full;
    logic [ADDR_W+1:0] w_level_next;

    assign w_level_next = {1'b0, w_mem_cnt_next} + (ADDR_W + 2)'(w_ob_cnt_next)
                        + (ADDR_W + 2)'(w_re);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_level       <= w_level_next;
            r_almost_full <= (w_level_next >= (ADDR_W + 2)'(DEPTH - 1));
        end
    end

    assign level       = r_level;
    assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed + randomised bench for ram_fifo_ctrl with a 1-cycle registered-read RAM model.
// Honours RAM_FIFO_LEVEL_EN to also check level / almost_full against the scoreboard.
module tb_ram_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
`ifdef RAM_FIFO_LEVEL_EN
    logic [ADDR_W+1:0] level;
    logic              almost_full;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int n_push  = 0;
    int n_pop   = 0;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] mem[DEPTH];

    ram_fifo_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef RAM_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1R1W RAM with registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake scoreboard, sampled mid-cycle while inputs are stable
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef RAM_FIFO_LEVEL_EN
            check_eq("level", 32'(level), 32'(sb.size()));
            check_eq("almost_full", 32'(almost_full), 32'(sb.size() >= DEPTH - 1));
`endif
            if (m_valid && m_ready) begin
                check_eq("pop_has_data", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check_eq("pop_data", 32'(m_data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
                n_pop++;
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                n_push++;
            end
        end
    end

    initial begin
        int acc;
        int base;
        int budget;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        ram_rdata = '0;

        // Reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_re", 32'(ram_re), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_s_ready_lo", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        check_eq("rel_s_ready_hi", 32'(s_ready), 32'd1);

        // Single word: push at t, visible at t+3 for one cycle
        step();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        @(negedge clk);
        check_eq("single_we", 32'(ram_we), 32'd1);
        check_eq("single_waddr", 32'(ram_waddr), 32'd0);
        check_eq("single_wdata", 32'(ram_wdata), 32'hA5);
        step();
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("single_re_t1", 32'(ram_re), 32'd1);
        check_eq("single_raddr", 32'(ram_raddr), 32'd0);
        check_eq("single_mv_t1", 32'(m_valid), 32'd0);
        step();
        @(negedge clk);
        check_eq("single_mv_t2", 32'(m_valid), 32'd0);
        check_eq("single_re_t2", 32'(ram_re), 32'd0);
        step();
        @(negedge clk);
        check_eq("single_mv_t3", 32'(m_valid), 32'd1);
        check_eq("single_md_t3", 32'(m_data), 32'hA5);
        step();
        @(negedge clk);
        check_eq("single_mv_t4", 32'(m_valid), 32'd0);

        // Fill with consumer stalled: 18 accepted, then blocked
        acc = 0;
        for (int k = 0; k < 21; k++) begin
            step();
            m_ready = 1'b0;
            s_valid = 1'b1;
            s_data  = 8'(acc);
            @(negedge clk);
            check_eq("fill_ready", 32'(s_ready), 32'(k < 18));
            if (s_ready) acc++;
        end
        check_eq("fill_count", 32'(acc), 32'd18);
        check_eq("fill_mv", 32'(m_valid), 32'd1);
        check_eq("fill_head", 32'(m_data), 32'd0);

        // Drain: 18 words back-to-back in order
        for (int k = 0; k < 18; k++) begin
            step();
            s_valid = 1'b0;
            m_ready = 1'b1;
            @(negedge clk);
            check_eq("drain_mv", 32'(m_valid), 32'd1);
            check_eq("drain_data", 32'(m_data), 32'(k));
        end
        step();
        @(negedge clk);
        check_eq("drain_mv_end", 32'(m_valid), 32'd0);
        check_eq("drain_s_ready", 32'(s_ready), 32'd1);

        // Streaming 40 words through wrapping pointers
        for (int i = 0; i < 45; i++) begin
            step();
            m_ready = 1'b1;
            s_valid = (i < 40);
            s_data  = 8'(i);
            @(negedge clk);
            if (i < 40) check_eq("stream_ready", 32'(s_ready), 32'd1);
            check_eq("stream_mv", 32'(m_valid), 32'((i >= 3) && (i < 43)));
            if ((i >= 3) && (i < 43)) check_eq("stream_data", 32'(m_data), 32'(i - 3));
        end

        // Random valid/ready for 1000 words
        base   = n_push;
        budget = 0;
        while ((n_push < base + 1000) && (budget < 20000)) begin
            step();
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            budget++;
        end
        check_eq("rand_push_done", 32'(n_push - base >= 1000), 32'd1);
        step();
        s_valid = 1'b0;
        m_ready = 1'b1;
        budget  = 0;
        while ((sb.size() != 0) && (budget < 100)) begin
            step();
            budget++;
        end
        repeat (4) step();
        @(negedge clk);
        check_eq("rand_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("rand_balance", 32'(n_pop), 32'(n_push));
        check_eq("rand_mv_idle", 32'(m_valid), 32'd0);
        check_eq("rand_s_ready", 32'(s_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
